// File: rtl/vend_ctrl.sv
// Vending-machine controller: credit accumulation, item vend and greedy coin change.
// Define VEND_STOCK_EN to compile in per-item stock counters and the sold_out output.
module vend_ctrl #(
    parameter int NUM_ITEMS  = 9,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [5:0]                      coin,
    input  logic [NUM_ITEMS-1:0]            select,
    input  logic                            cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   price,
    output logic [CREDIT_W-1:0]             state,
    output logic [NUM_ITEMS-1:0]            vend,
    output logic [5:0]                      change,
    output logic [CREDIT_W-1:0]             price_disp,
`ifdef VEND_STOCK_EN
    output logic [NUM_ITEMS-1:0]            sold_out,
`endif
    output logic                            busy
);

    // state    | meaning
    // S_IDLE   | no credit, waiting for coin or price lookup
    // S_CREDIT | credit held, accepting coins / select / cancel
    // S_VEND   | one-cycle dispense pulse for item_q
    // S_CHANGE | returning one coin per cycle until credit is zero
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} fsm_t;

    fsm_t                   fsm_q, fsm_d;
    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [CREDIT_W-1:0]    disp_q, disp_d;
    logic [NUM_ITEMS-1:0]   item_q, item_d;
    logic [5:0]             echo_q, echo_d;

    logic                   coin_ok, sel_ok, sel_blocked;
    logic [CREDIT_W-1:0]    coin_val, sel_price, chg_val;
    logic [CREDIT_W:0]      sum;
    logic [5:0]             chg_coin;

    assign coin_ok    = $onehot(coin);
    assign sel_ok     = $onehot(select);
    assign state      = credit_q;
    assign price_disp = disp_q;

    always_comb begin
        case (coin)
            6'b000001: coin_val = CREDIT_W'(1);
            6'b000010: coin_val = CREDIT_W'(2);
            6'b000100: coin_val = CREDIT_W'(5);
            6'b001000: coin_val = CREDIT_W'(10);
            6'b010000: coin_val = CREDIT_W'(20);
            6'b100000: coin_val = CREDIT_W'(100);
            default:   coin_val = '0;
        endcase
    end

    // Carry bit of the widened sum flags a credit overflow
    assign sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (select[i]) sel_price = price[i*CREDIT_W +: CREDIT_W];
        end
    end

    always_comb begin
        chg_coin = 6'b000000;
        chg_val  = '0;
        if (credit_q >= CREDIT_W'(100)) begin
            chg_coin = 6'b100000; chg_val = CREDIT_W'(100);
        end else if (credit_q >= CREDIT_W'(20)) begin
            chg_coin = 6'b010000; chg_val = CREDIT_W'(20);
        end else if (credit_q >= CREDIT_W'(10)) begin
            chg_coin = 6'b001000; chg_val = CREDIT_W'(10);
        end else if (credit_q >= CREDIT_W'(5)) begin
            chg_coin = 6'b000100; chg_val = CREDIT_W'(5);
        end else if (credit_q >= CREDIT_W'(2)) begin
            chg_coin = 6'b000010; chg_val = CREDIT_W'(2);
        end else if (credit_q >= CREDIT_W'(1)) begin
            chg_coin = 6'b000001; chg_val = CREDIT_W'(1);
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (reset) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end else if (fsm_q == S_VEND && item_q[i] && stock_q[i] != '0) begin
                stock_q[i] <= stock_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign sel_blocked = |(select & sold_out);
`else
    assign sel_blocked = 1'b0;
`endif

    always_comb begin
        fsm_d    = fsm_q;
        credit_d = credit_q;
        disp_d   = disp_q;
        item_d   = item_q;
        echo_d   = 6'b000000;
        vend     = '0;
        change   = echo_q;
        busy     = 1'b0;
        case (fsm_q)
            S_IDLE, S_CREDIT: begin
                if (coin_ok) begin
                    if (sum[CREDIT_W]) begin
                        echo_d = coin;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        fsm_d    = S_CREDIT;
                    end
                end else if (cancel && fsm_q == S_CREDIT) begin
                    fsm_d = S_CHANGE;
                end else if (sel_ok) begin
                    disp_d = sel_price;
                    if (fsm_q == S_CREDIT && credit_q >= sel_price && !sel_blocked) begin
                        credit_d = credit_q - sel_price;
                        item_d   = select;
                        fsm_d    = S_VEND;
                    end
                end
            end
            S_VEND: begin
                busy  = 1'b1;
                vend  = item_q;
                fsm_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                busy     = 1'b1;
                change   = chg_coin;
                credit_d = credit_q - chg_val;
                if (credit_q == chg_val) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            credit_q <= '0;
            disp_q   <= '0;
            item_q   <= '0;
            echo_q   <= 6'b000000;
        end else begin
            fsm_q    <= fsm_d;
            credit_q <= credit_d;
            disp_q   <= disp_d;
            item_q   <= item_d;
            echo_q   <= echo_d;
        end
    end

endmodule
